// File: rtl/serial_shift_rx_pkg.sv
// rtl/serial_shift_rx_pkg.sv - shared frame widths, counter width and receiver state enum
package serial_shift_pkg;

    localparam int SEG_FRAME_W = 64;
    localparam int LED_FRAME_W = 16;
    localparam int CNT_W       = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL,
        OVER
    } rx_state_t;

endpackage

// File: rtl/serial_shift_rx_if.sv
// rtl/serial_shift_rx_if.sv - serial shift-chain lines as produced by the display drivers
interface serial_shift_rx_if;

    logic s_clk;
    logic s_dat;
    logic s_pen;
    logic s_clrn;

    modport master (output s_clk, output s_dat, output s_pen, output s_clrn);
    modport slave  (input  s_clk, input  s_dat, input  s_pen, input  s_clrn);

endinterface

// File: rtl/serial_shift_rx_sync_edge.sv
// rtl/serial_shift_rx_sync_edge.sv - 2-flop synchronizer with a third flop for rising-edge detect
module sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic q1;
    logic q2;
    logic q3;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= RST_VAL;
            q2 <= RST_VAL;
            q3 <= RST_VAL;
        end else begin
            q1 <= d;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign level = q2;
    assign rise  = q2 & ~q3;

endmodule

// File: rtl/serial_shift_rx.sv
// rtl/serial_shift_rx.sv - shift-chain deserializer; SERIAL_SHIFT_RX_FRAME_ERR_EN rejects non-full frames
module serial_shift_rx
    import serial_shift_pkg::*;
#(
    parameter int WIDTH     = SEG_FRAME_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_shift_rx_if.slave     ser,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     bit_cnt,
    output logic                 busy
);

`ifdef SERIAL_SHIFT_RX_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic clk_rise;
    logic pen_rise;
    logic dat;
    logic clrn;
    logic s_clk_level_unused;
    logic s_pen_level_unused;
    logic s_dat_rise_unused;
    logic s_clrn_rise_unused;

    sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .d(ser.s_clk), .level(s_clk_level_unused), .rise(clk_rise)
    );
    sync_edge #(.RST_VAL(1'b0)) u_sync_dat (
        .clk(clk), .rst(rst), .d(ser.s_dat), .level(dat), .rise(s_dat_rise_unused)
    );
    sync_edge #(.RST_VAL(1'b0)) u_sync_pen (
        .clk(clk), .rst(rst), .d(ser.s_pen), .level(s_pen_level_unused), .rise(pen_rise)
    );
    sync_edge #(.RST_VAL(1'b1)) u_sync_clrn (
        .clk(clk), .rst(rst), .d(ser.s_clrn), .level(clrn), .rise(s_clrn_rise_unused)
    );

    rx_state_t        state;
    rx_state_t        state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             reject;
    logic             pend_ok;
    logic             pend_err;

    // Shift is resolved before the frame check so a coincident latch sees the new bit.
    always_comb begin
        sr_next    = sr;
        cnt_next   = bit_cnt;
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;

        if (clk_rise) begin
            if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], dat};
            else           sr_next = {dat, sr[WIDTH-1:1]};
            if (bit_cnt != CNT_MAX) cnt_next = bit_cnt + 7'd1;
            case (state)
                IDLE:    state_next = (cnt_next == CNT_FULL) ? FULL : SHIFT;
                SHIFT:   state_next = (cnt_next == CNT_FULL) ? FULL : SHIFT;
                FULL:    state_next = OVER;
                default: state_next = OVER;
            endcase
        end

        if (pen_rise) begin
            accept     = (state_next == FULL) || !ERR_EN;
            reject     = !accept;
            cnt_next   = '0;
            state_next = IDLE;
        end

        if (!clrn) begin
            sr_next    = '0;
            cnt_next   = '0;
            state_next = IDLE;
            accept     = 1'b0;
            reject     = 1'b0;
        end
    end

    // Pulses and data_out are registered one cycle after the action cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            pend_ok   <= 1'b0;
            pend_err  <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            bit_cnt   <= cnt_next;
            pend_ok   <= accept;
            pend_err  <= reject;
            valid     <= pend_ok;
            frame_err <= pend_err;
            if (pend_ok) data_out <= sr;
        end
    end

    assign busy = (bit_cnt != '0);

endmodule

// File: tb/tb_serial_shift_rx.sv
// tb/tb_serial_shift_rx.sv - self-checking bench for serial_shift_rx (16-bit MSB-first and 64-bit LSB-first)
module tb_serial_shift_rx;

`ifdef SERIAL_SHIFT_RX_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_shift_rx_if bus16();
    serial_shift_rx_if bus64();

    logic [15:0] data16;
    logic        v16, e16, busy16;
    logic [6:0]  cnt16;
    logic [63:0] data64;
    logic        v64, e64, busy64;
    logic [6:0]  cnt64;

    serial_shift_rx #(.WIDTH(16), .MSB_FIRST(1'b1)) u_dut16 (
        .clk(clk), .rst(rst), .ser(bus16.slave), .data_out(data16),
        .valid(v16), .frame_err(e16), .bit_cnt(cnt16), .busy(busy16)
    );
    serial_shift_rx #(.WIDTH(64), .MSB_FIRST(1'b0)) u_dut64 (
        .clk(clk), .rst(rst), .ser(bus64.slave), .data_out(data64),
        .valid(v64), .frame_err(e64), .bit_cnt(cnt64), .busy(busy64)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
    } ev_t;
    ev_t q16[$];
    ev_t q64[$];

    typedef struct {
        int          nbits;
        logic [63:0] bits;
        logic [6:0]  exp_cnt;
        bit          exp_ok;
        logic [63:0] exp_data;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic b);
        bus16.s_dat = b;
        repeat (4) cyc();
        bus16.s_clk = 1'b1;
        repeat (4) cyc();
        bus16.s_clk = 1'b0;
    endtask

    task automatic send_bits16(input int n, input logic [63:0] v);
        for (int i = n - 1; i >= 0; i--) send16(v[i]);
    endtask

    task automatic send64(input logic b);
        bus64.s_dat = b;
        repeat (4) cyc();
        bus64.s_clk = 1'b1;
        repeat (4) cyc();
        bus64.s_clk = 1'b0;
    endtask

    task automatic pen16();
        bus16.s_pen = 1'b1;
        repeat (4) cyc();
        bus16.s_pen = 1'b0;
        repeat (4) cyc();
    endtask

    // Scoreboard: every valid/frame_err pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (v16 || e16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL sb16: unexpected pulse valid=%b frame_err=%b", v16, e16);
                end else begin
                    ev_t ev;
                    ev = q16.pop_front();
                    if ({v16, e16} !== {!ev.is_err, ev.is_err} ||
                        (!ev.is_err && {48'd0, data16} !== ev.data)) begin
                        errors++;
                        $display("FAIL sb16: got valid=%b err=%b data=%h expected err=%b data=%h",
                                 v16, e16, data16, ev.is_err, ev.data);
                    end
                end
            end
            if (v64 || e64) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL sb64: unexpected pulse valid=%b frame_err=%b", v64, e64);
                end else begin
                    ev_t ev;
                    ev = q64.pop_front();
                    if ({v64, e64} !== {!ev.is_err, ev.is_err} ||
                        (!ev.is_err && data64 !== ev.data)) begin
                        errors++;
                        $display("FAIL sb64: got valid=%b err=%b data=%h expected err=%b data=%h",
                                 v64, e64, data64, ev.is_err, ev.data);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] last16;
        logic [63:0] pat64;
        int          lat;

        tbl[0] = '{nbits: 16, bits: 64'hA5C3,  exp_cnt: 7'd16, exp_ok: 1'b1,    exp_data: 64'hA5C3};
        tbl[1] = '{nbits: 15, bits: 64'h1234,  exp_cnt: 7'd15, exp_ok: !ERR_EN, exp_data: 64'h9234};
        tbl[2] = '{nbits: 18, bits: 64'h3BEEF, exp_cnt: 7'd17, exp_ok: !ERR_EN, exp_data: 64'hBEEF};
        tbl[3] = '{nbits: 0,  bits: 64'h0,     exp_cnt: 7'd0,  exp_ok: !ERR_EN, exp_data: 64'hBEEF};

        bus16.s_clk = 0; bus16.s_dat = 0; bus16.s_pen = 0; bus16.s_clrn = 1;
        bus64.s_clk = 0; bus64.s_dat = 0; bus64.s_pen = 0; bus64.s_clrn = 1;
        rst = 1'b1;
        repeat (4) cyc();
        check("reset data16", {48'd0, data16}, 64'd0);
        check("reset cnt16", {57'd0, cnt16}, 64'd0);
        check("reset flags16", {61'd0, v16, e16, busy16}, 64'd0);
        check("reset data64", data64, 64'd0);
        rst = 1'b0;
        repeat (4) cyc();

        last16 = 16'h0;
        for (int r = 0; r < 4; r++) begin
            send_bits16(tbl[r].nbits, tbl[r].bits);
            repeat (4) cyc();
            check($sformatf("row%0d cnt", r), {57'd0, cnt16}, {57'd0, tbl[r].exp_cnt});
            check($sformatf("row%0d busy", r), {63'd0, busy16}, {63'd0, tbl[r].exp_cnt != 7'd0});
            q16.push_back('{is_err: !tbl[r].exp_ok, data: tbl[r].exp_data});
            pen16();
            if (tbl[r].exp_ok) last16 = tbl[r].exp_data[15:0];
            check($sformatf("row%0d cnt after", r), {57'd0, cnt16}, 64'd0);
            check($sformatf("row%0d data_out", r), {48'd0, data16}, {48'd0, last16});
        end

        // Clear mid-frame
        send_bits16(8, 64'hFF);
        repeat (4) cyc();
        check("pre-clear cnt", {57'd0, cnt16}, 64'd8);
        bus16.s_clrn = 1'b0;
        repeat (5) cyc();
        check("clear cnt", {57'd0, cnt16}, 64'd0);
        check("clear busy", {63'd0, busy16}, 64'd0);
        bus16.s_clrn = 1'b1;
        repeat (4) cyc();
        check("clear data held", {48'd0, data16}, {48'd0, last16});
        send_bits16(16, 64'h1234);
        q16.push_back('{is_err: 1'b0, data: 64'h1234});
        pen16();
        last16 = 16'h1234;
        check("post-clear frame", {48'd0, data16}, 64'h1234);

        // Coincident s_clk and s_pen on bit 16
        send_bits16(15, 64'h2D2D);
        repeat (4) cyc();
        bus16.s_dat = 1'b0;
        repeat (4) cyc();
        q16.push_back('{is_err: 1'b0, data: 64'h5A5A});
        bus16.s_clk = 1'b1;
        bus16.s_pen = 1'b1;
        repeat (4) cyc();
        bus16.s_clk = 1'b0;
        bus16.s_pen = 1'b0;
        repeat (4) cyc();
        last16 = 16'h5A5A;
        check("coincident data", {48'd0, data16}, 64'h5A5A);
        check("coincident cnt", {57'd0, cnt16}, 64'd0);

        // 64-bit LSB-first frame with latency measurement
        pat64 = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 64; i++) send64(pat64[i]);
        repeat (4) cyc();
        check("w64 cnt", {57'd0, cnt64}, 64'd64);
        q64.push_back('{is_err: 1'b0, data: pat64});
        bus64.s_pen = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (v64) begin
                lat = k;
                break;
            end
        end
        check("w64 valid latency", 64'(lat), 64'd4);
        cyc();
        bus64.s_pen = 1'b0;
        repeat (4) cyc();
        check("w64 data_out", data64, pat64);
        check("w64 cnt after", {57'd0, cnt64}, 64'd0);

        // Reset mid-frame, then a latch in IDLE right after reset
        send_bits16(5, 64'h15);
        repeat (4) cyc();
        check("pre-reset cnt", {57'd0, cnt16}, 64'd5);
        rst = 1'b1;
        repeat (2) cyc();
        check("mid reset data", {48'd0, data16}, 64'd0);
        check("mid reset flags", {57'd0, cnt16, v16, e16, busy16} >> 3, 64'd0);
        check("mid reset pulses", {61'd0, v16, e16, busy16}, 64'd0);
        rst = 1'b0;
        repeat (4) cyc();
        q16.push_back('{is_err: ERR_EN, data: 64'h0});
        pen16();
        check("post-reset data", {48'd0, data16}, 64'd0);

        repeat (10) cyc();
        check("sb16 drained", 64'(q16.size()), 64'd0);
        check("sb64 drained", 64'(q64.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
